// File: rtl/c7b_biu_pkg.sv
// Shared definitions for the bus interface unit: FSM states and AXI constants.
package c7b_biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARQ   = 2'd1,
        ST_RDAT  = 2'd2,
        ST_DRAIN = 2'd3
    } ird_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         IC_LINE_BEATS  = 4;

endpackage

// File: rtl/c7bbiu_ird.sv
// Instruction-read responder: turns an icache linefill/single request into
// one AXI4 INCR read burst and streams the beats back with a registered
// valid/last/fault stage. Malformed bursts (rlast early or late) are
// terminated toward the icache with fault set; late tails are drained.
module c7bbiu_ird
    import c7b_biu_pkg::*;
#(
    parameter logic [3:0] ARID_VAL   = 4'h0,
    parameter int         LINE_BEATS = IC_LINE_BEATS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        icu_biu_req,
    input  logic [31:3] icu_biu_addr,
    input  logic        icu_biu_single,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic        biu_icu_data_last,
    output logic [63:0] biu_icu_data,
    output logic        biu_icu_fault,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [31:0] axi_araddr,
    output logic [3:0]  axi_arid,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    input  logic [63:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast
);

    ird_state_e  state_reg, state_next;
    logic [31:0] araddr_reg, araddr_next;
    logic [7:0]  arlen_reg, arlen_next;
    logic [1:0]  beat_cnt_reg, beat_cnt_next;
    logic        err_reg, err_next;
    logic        dv_reg, dv_next;
    logic        dl_reg, dl_next;
    logic        fault_reg, fault_next;
    logic [63:0] data_reg, data_next;

    logic        exp_last;
    logic        beat_err;

    // The beat that the burst length says is final; counter never passes it.
    assign exp_last = (beat_cnt_reg == arlen_reg[1:0]);
    // SLVERR/DECERR both carry bit 1; EXOKAY is treated as success.
    assign beat_err = (axi_rresp != AXI_RESP_OKAY) && axi_rresp[1];

    assign axi_araddr         = araddr_reg;
    assign axi_arlen          = arlen_reg;
    assign axi_arid           = ARID_VAL;
    assign axi_arsize         = AXI_SIZE_8B;
    assign axi_arburst        = AXI_BURST_INCR;
    assign biu_icu_data_valid = dv_reg;
    assign biu_icu_data_last  = dl_reg;
    assign biu_icu_fault      = fault_reg;
    assign biu_icu_data       = data_reg;

    // Next-state, AXI handshake outputs and the next value of the output stage.
    always_comb begin
        state_next    = state_reg;
        araddr_next   = araddr_reg;
        arlen_next    = arlen_reg;
        beat_cnt_next = beat_cnt_reg;
        err_next      = err_reg;
        dv_next       = 1'b0;
        dl_next       = 1'b0;
        fault_next    = 1'b0;
        data_next     = data_reg;
        axi_arvalid   = 1'b0;
        axi_rready    = 1'b0;
        biu_icu_ack   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (icu_biu_req) begin
                    araddr_next = {icu_biu_addr, 3'b000};
                    arlen_next  = icu_biu_single ? 8'd0 : 8'(LINE_BEATS - 1);
                    state_next  = ST_ARQ;
                end
            end
            ST_ARQ: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    biu_icu_ack   = 1'b1;
                    beat_cnt_next = 2'd0;
                    err_next      = 1'b0;
                    state_next    = ST_RDAT;
                end
            end
            ST_RDAT: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    data_next = axi_rdata;
                    dv_next   = 1'b1;
                    err_next  = err_reg | beat_err;
                    if (exp_last || axi_rlast) begin
                        // Any disagreement between rlast and the length ends the line as faulty.
                        dl_next    = 1'b1;
                        fault_next = err_reg | beat_err | (exp_last != axi_rlast);
                        state_next = axi_rlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 2'd1;
                    end
                end
            end
            ST_DRAIN: begin
                axi_rready = 1'b1;
                if (axi_rvalid && axi_rlast) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, AR registers, beat tracking and the registered icache output stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            araddr_reg   <= 32'd0;
            arlen_reg    <= 8'd0;
            beat_cnt_reg <= 2'd0;
            err_reg      <= 1'b0;
            dv_reg       <= 1'b0;
            dl_reg       <= 1'b0;
            fault_reg    <= 1'b0;
            data_reg     <= 64'd0;
        end else begin
            state_reg    <= state_next;
            araddr_reg   <= araddr_next;
            arlen_reg    <= arlen_next;
            beat_cnt_reg <= beat_cnt_next;
            err_reg      <= err_next;
            dv_reg       <= dv_next;
            dl_reg       <= dl_next;
            fault_reg    <= fault_next;
            data_reg     <= data_next;
        end
    end

endmodule

// File: tb/tb_c7bbiu_ird.sv
// Bench for c7bbiu_ird: directed and random requests against a transaction
// model that predicts AR fields and the icache beat stream per burst.
module tb_c7bbiu_ird;

    localparam logic [3:0] ARID = 4'h5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        icu_biu_req;
    logic [31:3] icu_biu_addr;
    logic        icu_biu_single;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic        biu_icu_data_last;
    logic [63:0] biu_icu_data;
    logic        biu_icu_fault;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;

    c7bbiu_ird #(.ARID_VAL(ARID), .LINE_BEATS(4)) dut (
        .clk(clk), .resetn(resetn),
        .icu_biu_req(icu_biu_req), .icu_biu_addr(icu_biu_addr), .icu_biu_single(icu_biu_single),
        .biu_icu_ack(biu_icu_ack), .biu_icu_data_valid(biu_icu_data_valid),
        .biu_icu_data_last(biu_icu_data_last), .biu_icu_data(biu_icu_data),
        .biu_icu_fault(biu_icu_fault),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        bit          last;
        bit          fault;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          dv_seen = 0;
    logic [63:0] last_data = '0;
    logic        last_fault = 1'b0;
    logic [31:0] ar_cap;
    logic [7:0]  arlen_cap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle check of the icache-facing stream against the predicted beats.
    always @(negedge clk) begin
        if (resetn) begin
            if (biu_icu_data_valid === 1'b1) dv_seen++;
            if (biu_icu_data_last === 1'b1) begin
                last_data  = biu_icu_data;
                last_fault = biu_icu_fault;
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_valid", 64'(biu_icu_data_valid), 64'd1);
                chk("data", biu_icu_data, e.data);
                chk("data_last", 64'(biu_icu_data_last), 64'(e.last));
                if (e.last) chk("fault", 64'(biu_icu_fault), 64'(e.fault));
            end else begin
                chk("no_valid", 64'(biu_icu_data_valid), 64'd0);
                chk("no_last", 64'(biu_icu_data_last), 64'd0);
            end
        end
    end

    // One request: AR phase with ard wait cycles, then nb R beats (rlast on the
    // nb-th), errm marks error beats. rst_beat >= 0 pulls reset while that beat is offered.
    task automatic txn(input logic [28:0] a, input bit sgl, input int ard, input int nb,
                       input logic [7:0] errm, input bit dirdata, input logic [63:0] dbase,
                       input int gapmax, input int rst_beat);
        int          e;
        int          nout;
        bit          flt;
        logic [31:0] ea;
        logic [7:0]  el;
        e    = sgl ? 1 : 4;
        ea   = {a, 3'b000};
        el   = sgl ? 8'd0 : 8'd3;
        nout = (nb < e) ? nb : e;
        flt  = 1'b1;
        if (nb == e) begin
            flt = 1'b0;
            for (int i = 0; i < e; i++) if (errm[i]) flt = 1'b1;
        end
        icu_biu_req    = 1'b1;
        icu_biu_addr   = a;
        icu_biu_single = sgl;
        @(negedge clk);
        chk("ar_latency", 64'(axi_arvalid), 64'd1);
        chk("araddr", 64'(axi_araddr), 64'(ea));
        chk("arlen", 64'(axi_arlen), 64'(el));
        chk("arid", 64'(axi_arid), 64'(ARID));
        chk("arsize", 64'(axi_arsize), 64'd3);
        chk("arburst", 64'(axi_arburst), 64'd1);
        ar_cap    = axi_araddr;
        arlen_cap = axi_arlen;
        for (int k = 0; k < ard; k++) begin
            chk("ack_early", 64'(biu_icu_ack), 64'd0);
            @(negedge clk);
            chk("arvalid_hold", 64'(axi_arvalid), 64'd1);
            chk("araddr_hold", 64'(axi_araddr), 64'(ea));
        end
        axi_arready = 1'b1;
        #1;
        chk("ack", 64'(biu_icu_ack), 64'd1);
        @(negedge clk);
        axi_arready = 1'b0;
        chk("ack_pulse", 64'(biu_icu_ack), 64'd0);
        chk("no_second_ar", 64'(axi_arvalid), 64'd0);
        for (int i = 0; i < nb; i++) begin
            int g;
            g = $urandom_range(gapmax, 0);
            for (int k = 0; k < g; k++) begin
                axi_rvalid = 1'b0;
                @(negedge clk);
                icu_biu_req = 1'b0;
                chk("no_second_ar", 64'(axi_arvalid), 64'd0);
            end
            axi_rdata  = dirdata ? dbase + 64'(i) : {$urandom, $urandom};
            axi_rresp  = errm[i] ? 2'b10 : ($urandom_range(1, 0) == 1 ? 2'b01 : 2'b00);
            axi_rlast  = (i == nb - 1);
            axi_rvalid = 1'b1;
            chk("rready", 64'(axi_rready), 64'd1);
            if (i == rst_beat) begin
                #2 resetn = 1'b0;
                #1;
                chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
                chk("rst_rready", 64'(axi_rready), 64'd0);
                chk("rst_ack", 64'(biu_icu_ack), 64'd0);
                chk("rst_valid", 64'(biu_icu_data_valid), 64'd0);
                chk("rst_last", 64'(biu_icu_data_last), 64'd0);
                chk("rst_fault", 64'(biu_icu_fault), 64'd0);
                chk("rst_data", biu_icu_data, 64'd0);
                chk("rst_araddr", 64'(axi_araddr), 64'd0);
                chk("rst_arlen", 64'(axi_arlen), 64'd0);
                exp_q.delete();
                axi_rvalid  = 1'b0;
                axi_rlast   = 1'b0;
                icu_biu_req = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                $display("txn addr=%08h single=%0d reset during beat %0d", ea, sgl, i + 1);
                return;
            end
            if (i < nout) exp_q.push_back('{cyc + 1, axi_rdata, (i == nout - 1), flt});
            @(negedge clk);
            icu_biu_req = 1'b0;
            chk("no_second_ar", 64'(axi_arvalid), 64'd0);
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        $display("txn addr=%08h single=%0d ar_wait=%0d beats=%0d errm=%02h exp_fault=%0d",
                 ea, sgl, ard, nb, errm, flt);
    endtask

    initial begin
        int d0;
        resetn         = 1'b0;
        icu_biu_req    = 1'b0;
        icu_biu_addr   = '0;
        icu_biu_single = 1'b0;
        axi_arready    = 1'b0;
        axi_rvalid     = 1'b0;
        axi_rdata      = '0;
        axi_rresp      = 2'b00;
        axi_rlast      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_arvalid", 64'(axi_arvalid), 64'd0);
        chk("reset_valid", 64'(biu_icu_data_valid), 64'd0);
        chk("reset_data", biu_icu_data, 64'd0);
        chk("reset_araddr", 64'(axi_araddr), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Line fill, immediate arready, beats 0xA0..0xA3.
        d0 = dv_seen;
        txn(29'h0200_0008, 1'b0, 0, 4, 8'h00, 1'b1, 64'hA0, 0, -1);
        @(negedge clk); #1;
        chk("pin_araddr", 64'(ar_cap), 64'h1000_0040);
        chk("pin_arlen", 64'(arlen_cap), 64'd3);
        chk("pin_beats", 64'(dv_seen - d0), 64'd4);
        chk("pin_last_data", last_data, 64'hA3);
        chk("pin_fault", 64'(last_fault), 64'd0);

        // Single-beat read at 0x2000_0008.
        d0 = dv_seen;
        txn(29'h0400_0001, 1'b1, 0, 1, 8'h00, 1'b1, 64'h55, 0, -1);
        @(negedge clk); #1;
        chk("pin_single_arlen", 64'(arlen_cap), 64'd0);
        chk("pin_single_beats", 64'(dv_seen - d0), 64'd1);
        chk("pin_single_data", last_data, 64'h55);

        // arready held low five cycles.
        txn(29'h0000_1230, 1'b0, 5, 4, 8'h00, 1'b1, 64'hB0, 0, -1);
        @(negedge clk);

        // SLVERR on beat 2 of 4.
        d0 = dv_seen;
        txn(29'h0000_2000, 1'b0, 1, 4, 8'h02, 1'b1, 64'hC0, 0, -1);
        @(negedge clk); #1;
        chk("pin_err_beats", 64'(dv_seen - d0), 64'd4);
        chk("pin_err_fault", 64'(last_fault), 64'd1);

        // rlast missing on beat 4, arrives on beat 6.
        d0 = dv_seen;
        txn(29'h0000_3000, 1'b0, 0, 6, 8'h00, 1'b1, 64'hD0, 0, -1);
        @(negedge clk); #1;
        chk("pin_late_beats", 64'(dv_seen - d0), 64'd4);
        chk("pin_late_data", last_data, 64'hD3);
        chk("pin_late_fault", 64'(last_fault), 64'd1);

        // Reset during beat 2, then a clean line fill.
        txn(29'h0000_4000, 1'b0, 0, 4, 8'h00, 1'b1, 64'hE0, 0, 1);
        d0 = dv_seen;
        txn(29'h0000_5000, 1'b0, 0, 4, 8'h00, 1'b1, 64'hF0, 0, -1);
        @(negedge clk); #1;
        chk("pin_post_rst_beats", 64'(dv_seen - d0), 64'd4);
        chk("pin_post_rst_data", last_data, 64'hF3);
        chk("pin_post_rst_fault", 64'(last_fault), 64'd0);

        // Randomized requests, including early/late rlast and error beats.
        for (int n = 0; n < 150; n++) begin
            bit          sgl;
            int          nb;
            int          mode;
            logic [28:0] a;
            logic [7:0]  em;
            sgl  = ($urandom_range(3, 0) == 0);
            a    = 29'($urandom);
            if (!sgl) a[1:0] = 2'b00;
            mode = $urandom_range(5, 0);
            if (mode == 4 && !sgl)   nb = $urandom_range(3, 1);
            else if (mode == 5)      nb = (sgl ? 1 : 4) + $urandom_range(2, 1);
            else                     nb = sgl ? 1 : 4;
            em = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h00;
            txn(a, sgl, $urandom_range(5, 0), nb, em, 1'b0, 64'd0, $urandom_range(2, 0), -1);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        chk("pending_beats", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c7bbiu_ird.md
# c7bbiu_ird

Instruction-read responder of the bus interface unit: the far end of the icache linefill port (`icu_biu_*` / `biu_icu_*`). It accepts one line-fill or single-beat request at a time, issues an AXI4 read burst, and streams the returned 64-bit beats back to the icache with `data_valid`/`data_last` and an error flag. It sits between the icache unit and the system AXI interconnect.

## Interface
- `ARID_VAL`, default 4'h0: constant ARID driven on every request.
- `LINE_BEATS`, default 4: beats per line fill (32-byte line / 64-bit bus); must be 4 in this design.
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `icu_biu_req` in 1: request, held until `biu_icu_ack`.
- `icu_biu_addr` in [31:3]: beat address; line fills are 32-byte aligned.
- `icu_biu_single` in 1: 1 = one beat, 0 = line fill.
- `biu_icu_ack` out 1: one-cycle pulse, request accepted.
- `biu_icu_data_valid` out 1: beat valid, registered.
- `biu_icu_data_last` out 1: final beat, coincident with its `data_valid`.
- `biu_icu_data` out 64: beat data.
- `biu_icu_fault` out 1: error, valid only with `data_last`.
- `axi_arvalid` out 1, `axi_arready` in 1, `axi_araddr` out 32, `axi_arid` out 4, `axi_arlen` out 8, `axi_arsize` out 3 (fixed 3'b011), `axi_arburst` out 2 (fixed INCR 2'b01).
- `axi_rvalid` in 1, `axi_rready` out 1, `axi_rdata` in 64, `axi_rresp` in 2, `axi_rlast` in 1.

## Operation
- States: IDLE, ARQ, RDAT, DRAIN.
- IDLE: `icu_biu_req`=1 → latch addr and single; → ARQ. `axi_araddr` = {addr,3'b000}; `axi_arlen` = single ? 0 : 3.
- ARQ: `axi_arvalid`=1. On `axi_arready`, `biu_icu_ack`=1 (combinational, `arvalid & arready`), clear beat counter and error flag, → RDAT.
- RDAT: `axi_rready`=1. Each R handshake → data output register loads `rdata`; `data_valid` asserts next cycle; beat counter increments (2 bits, no wrap beyond expected count). `rresp[1]`=1 on any beat sets sticky error.
- Expected last = counter equals `axi_arlen`. `rlast` and expected last together → output `data_last`, → IDLE.
- Early `rlast` (before expected) → output that beat as `data_last` with `fault`=1, → IDLE.
- Expected last without `rlast` → output `data_last` with `fault`=1, → DRAIN.
- DRAIN: `axi_rready`=1, beats discarded, no `data_valid`; `rlast` → IDLE.
- `biu_icu_fault` = sticky error OR the final beat's `rresp[1]` OR rlast mismatch, registered with `data_last`.
- `icu_biu_req` is ignored outside IDLE. A stale `req` in the cycle after ack does not start a new request, because the FSM is in RDAT.

## Timing
- Reset: state IDLE; `arvalid`, `rready`, `ack`, `data_valid`, `data_last`, `fault` = 0; `data` = 0; `araddr`/`arlen` = 0.
- `req` at cycle t in IDLE → `arvalid` at t+1. `ack` in the AR handshake cycle, minimum t+1.
- R handshake at cycle u → `data_valid` (and `data_last`/`fault`) at u+1. Beats are back-to-back when `rvalid` is continuous.
- `data_valid` is never asserted in the ack cycle. The first beat is at earliest ack+2.
- IDLE is re-entered in the cycle `data_last` is driven. A `req` there is accepted, so the next `arvalid` follows at +1.
- Reset mid-operation: immediate return to IDLE, outputs cleared, outstanding burst abandoned. The interconnect shares `resetn`.

## Structure
- Shared package `c7b_biu_pkg`: FSM state enum; AXI constants `AXI_BURST_INCR`, `AXI_SIZE_8B`, `AXI_RESP_OKAY`; `IC_LINE_BEATS` = 4.
- Flat module; no sub-module warranted. The output register stage and counter are inline.

## Test plan
- Line fill, addr 0x1000_0040>>3, `arready` immediate, 4 beats back-to-back 0xA0..0xA3 with `rlast` on beat 4:
  - `ack` one cycle, `arlen`=3, `araddr`=0x1000_0040.
  - `data_valid` for 4 cycles, `data_last` with 0xA3, `fault`=0.
- Single read (`single`=1), addr 0x2000_0008:
  - `arlen`=0.
  - One beat with `data_valid`=`data_last`=1.
- `arready` low 5 cycles with `req` held:
  - `arvalid` stable, `araddr` stable, no `ack` until handshake.
  - `req` held high 1 cycle after `ack` → no second AR.
- `rresp`=SLVERR on beat 2 of 4 → `data_valid` on all 4 beats, `fault`=1 only on the `data_last` cycle.
- `rlast` missing on beat 4, sent on beat 6:
  - `data_last`+`fault` on beat 4.
  - Beats 5–6 consumed with no `data_valid`.
  - Returns to IDLE, next `req` serviced normally.
- `resetn` low during beat 2 → all outputs 0 asynchronously, FSM IDLE, and a new request after reset completes correctly.
